// File: rtl/seq_detect_arb.sv
// Two-requester round-robin arbiter feeding a WIDTH-bit word MSB-first into a Mealy "0011" detector.
// Optional match interrupt (irq/irq_clr) is built when SEQ_MATCH_IRQ_EN is defined.
module seq_detect_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             busy,
  output logic             ser_bit,
  output logic             det_z,
  output logic             done,
  output logic             done_id,
  output logic [3:0]       match_cnt
`ifdef SEQ_MATCH_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {DET_A, DET_B, DET_C, DET_D} det_t;

  state_t           state;
  det_t             det_state;
  det_t             det_next;
  logic [WIDTH-1:0] shift_reg;
  logic [4:0]       bit_cnt;
  logic [3:0]       run_cnt;
  logic [3:0]       cnt_next;
  logic             last_grant;
  logic             cur_id;
  logic             grant1;
  logic             last_bit;

  // last_grant records who was served most recently; the other side wins a tie.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req1_ready = reset && (state == IDLE) && grant1;
    req0_ready = reset && (state == IDLE) && req0_valid && !grant1;
  end

  // The shift register drains to zero, so ser_bit is 0 whenever no word is in flight.
  assign ser_bit  = shift_reg[WIDTH-1];
  assign busy     = (state != IDLE);
  assign last_bit = (bit_cnt == 5'(WIDTH - 1));

  always_comb begin
    det_next = det_state;
    det_z    = 1'b0;
    if (state == SHIFT) begin
      case (det_state)
        DET_A: det_next = ser_bit ? DET_A : DET_B;
        DET_B: det_next = ser_bit ? DET_A : DET_C;
        DET_C: det_next = ser_bit ? DET_D : DET_C;
        DET_D: begin
          det_next = ser_bit ? DET_A : DET_B;
          det_z    = ser_bit;
        end
        default: det_next = DET_A;
      endcase
    end
    cnt_next = (det_z && run_cnt != 4'd15) ? run_cnt + 4'd1 : run_cnt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      det_state  <= DET_A;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      run_cnt    <= '0;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      match_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            shift_reg  <= grant1 ? req1_data : req0_data;
            last_grant <= grant1;
            cur_id     <= grant1;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            det_state  <= DET_A;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          det_state <= det_next;
          run_cnt   <= cnt_next;
          bit_cnt   <= bit_cnt + 5'd1;
          if (last_bit) begin
            state     <= DONE;
            done      <= 1'b1;
            match_cnt <= cnt_next;
            done_id   <= cur_id;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_MATCH_IRQ_EN
  // Raised on the same edge as done; a coincident clear loses to a new set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq <= 1'b0;
    end else if (state == SHIFT && last_bit && cnt_next != 4'd0) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_arb.sv
// Randomized bench for seq_detect_arb against a word-level model (substring count of "0011").
// Covers the irq feature only when SEQ_MATCH_IRQ_EN is defined.
module tb_seq_detect_arb;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready, busy, ser_bit, det_z, done, done_id;
  logic [3:0]   match_cnt;
`ifdef SEQ_MATCH_IRQ_EN
  logic         irq_clr = 1'b0;
  logic         irq;
  bit           clr_on_last = 1'b0;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int last_served = 1;
  int exp_match = 0;
  int exp_id = 0;

  seq_detect_arb #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .busy(busy), .ser_bit(ser_bit), .det_z(det_z),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
`ifdef SEQ_MATCH_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Bit k (0 = first shifted) of the word.
  function automatic int bit_at(input logic [W-1:0] d, input int k);
    return int'(d[W-1-k]);
  endfunction

  // True when the four bits ending at step k read 0,0,1,1 in shift order.
  function automatic int hit_at(input logic [W-1:0] d, input int k);
    if (k < 3) return 0;
    return (bit_at(d, k-3) == 0 && bit_at(d, k-2) == 0 &&
            bit_at(d, k-1) == 1 && bit_at(d, k) == 1) ? 1 : 0;
  endfunction

  function automatic int count_hits(input logic [W-1:0] d);
    int c = 0;
    for (int k = 0; k < W; k++) c += hit_at(d, k);
    return (c > 15) ? 15 : c;
  endfunction

  // Called at a negedge inside an IDLE cycle; returns at a negedge inside the following IDLE cycle.
  task automatic run_txn(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input int abort_at);
    int win;
    logic [W-1:0] wd;
    int exp_cnt;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    #1;
    check("busy_idle", busy, 0);
    check("done_idle", done, 0);
    check("cnt_hold", match_cnt, exp_match);
    check("id_hold", done_id, exp_id);
    if (!v0 && !v1) begin
      check("rdy0_none", req0_ready, 0);
      check("rdy1_none", req1_ready, 0);
      @(negedge clk);
      return;
    end
    if (v0 && v1) win = 1 - last_served;
    else win = v1 ? 1 : 0;
    check("rdy0_grant", req0_ready, (win == 0) ? 1 : 0);
    check("rdy1_grant", req1_ready, win);
    $display("txn: v0=%0d v1=%0d d0=%h d1=%h -> grant req%0d", v0, v1, d0, d1, win);
    last_served = win;
    wd = (win == 1) ? d1 : d0;
    exp_cnt = count_hits(wd);
    @(posedge clk);
    #1;
    // Activity on the request side while shifting must be ignored.
    req0_valid = 1'($urandom_range(0, 1)); req0_data = W'($urandom);
    req1_valid = 1'($urandom_range(0, 1)); req1_data = W'($urandom);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("busy_shift", busy, 1);
      check("ser_bit", ser_bit, bit_at(wd, k));
      check("det_z", det_z, hit_at(wd, k));
      check("rdy0_shift", req0_ready, 0);
      check("rdy1_shift", req1_ready, 0);
      check("done_early", done, 0);
      if (k + 1 == abort_at) begin
        reset = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_ser", ser_bit, 0);
        check("abort_cnt", match_cnt, 0);
        check("abort_id", done_id, 0);
        check("abort_rdy0", req0_ready, 0);
        check("abort_rdy1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        last_served = 1; exp_match = 0; exp_id = 0;
`ifdef SEQ_MATCH_IRQ_EN
        check("abort_irq", irq, 0);
`endif
        return;
      end
`ifdef SEQ_MATCH_IRQ_EN
      if (k == W - 1 && clr_on_last) irq_clr = 1'b1;
`endif
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("match_cnt", match_cnt, exp_cnt);
    check("done_id", done_id, win);
    check("busy_done", busy, 1);
    check("rdy0_done", req0_ready, 0);
    check("rdy1_done", req1_ready, 0);
    $display("done: id=%0d match_cnt=%0d (model %0d)", done_id, match_cnt, exp_cnt);
    exp_match = exp_cnt; exp_id = win;
`ifdef SEQ_MATCH_IRQ_EN
    irq_clr = 1'b0;
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_id", done_id, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_ser", ser_bit, 0);
    check("rst_det", det_z, 0);
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;

    // Tie from reset: req0, req1, req0.
    for (int i = 0; i < 3; i++) run_txn(1'b1, 8'h33, 1'b1, 8'h03, 0);
    run_txn(1'b1, 8'b0011_0011, 1'b0, 8'h00, 0);
    run_txn(1'b0, 8'h00, 1'b1, 8'b0000_0011, 0);
    run_txn(1'b0, 8'h00, 1'b1, 8'b1111_1111, 0);
    // Abandon a word on the 4th shift cycle, then a clean tie restarts at req0.
    run_txn(1'b0, 8'h00, 1'b1, 8'b0011_0011, 4);
    run_txn(1'b1, 8'b0011_0011, 1'b1, 8'b0000_0011, 0);

    for (int i = 0; i < 30; i++)
      run_txn(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom), 0);

`ifdef SEQ_MATCH_IRQ_EN
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_pre", irq, 0);
    run_txn(1'b0, 8'h00, 1'b1, 8'b0000_0011, 0);
    check("irq_set", irq, 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("irq_clr", irq, 0);
    clr_on_last = 1'b1;
    run_txn(1'b1, 8'b0011_0011, 1'b0, 8'h00, 0);
    clr_on_last = 1'b0;
    check("irq_set_wins", irq, 1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    run_txn(1'b1, 8'hFF, 1'b0, 8'h00, 0);
    check("irq_nomatch", irq, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/seq_detect_arb.md
SEQ_DETECT_ARB -- requirements
Module: seq_detect_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length shifted per transaction (legal 4..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester word offered.
REQ-005 SHALL have ports req0_data / req1_data  input  WIDTH  requester word, MSB shifted first.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  grant/accept; transfer on valid&ready.
REQ-007 SHALL have port busy  output  1  high from handshake cycle+1 until the done cycle inclusive.
REQ-008 SHALL have port ser_bit  output  1  serial bit currently fed to the detector.
REQ-009 SHALL have port det_z  output  1  Mealy detector output for ser_bit, combinational.
REQ-010 SHALL have port done  output  1  one-cycle pulse, word fully processed.
REQ-011 SHALL have port done_id  output  1  requester index of finished word; held until next done.
REQ-012 SHALL have port match_cnt  output  4  matches in finished word; held until next done.

Function
REQ-013 Controller FSM SHALL have states IDLE, SHIFT, DONE.
REQ-014 IDLE: ready SHALL be asserted combinationally to exactly one requester (the grant) when at least one valid is high; never to both.
REQ-015 Grant SHALL be round-robin: single valid wins; both valid -> requester not served last wins; last_grant pointer updates only on handshake.
REQ-016 Handshake cycle SHALL load shift register with granted data, clear bit counter and running count, set detector to state A, and move to SHIFT.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, presenting data[WIDTH-1] down to data[0] on ser_bit, one bit per cycle.
REQ-018 Detector SHALL detect pattern 0011 with transitions: A:0->B,1->A; B:0->C,1->A; C:0->C,1->D; D:0->B,1->A with det_z=1; det_z=0 in all other cases.
REQ-019 Detector state SHALL advance only in SHIFT; det_z SHALL be 0 outside SHIFT.
REQ-020 Running count SHALL increment on each SHIFT cycle with det_z=1, saturating at 15.
REQ-021 After last bit, FSM SHALL enter DONE for one cycle: done=1, match_cnt and done_id updated; then return to IDLE.
REQ-022 Transaction latency SHALL be fixed: done asserted WIDTH+1 cycles after the handshake edge; next handshake earliest in cycle after DONE.
REQ-023 ready SHALL be 0 in SHIFT and DONE; valid changes during SHIFT SHALL have no effect.
REQ-024 A requester kept waiting SHALL keep its valid/data pending without loss; no timeout.

Reset
REQ-025 reset low at a clock edge SHALL force IDLE, detector A, counters 0, last_grant=1 (req0 wins first tie), done=0, done_id=0, match_cnt=0, busy=0, ser_bit=0.
REQ-026 Reset mid-SHIFT SHALL abandon the word with no done pulse; ready SHALL be 0 while reset is low.

Configuration
REQ-027 Macro SEQ_MATCH_IRQ_EN defined SHALL add input irq_clr (1) and output irq (1): irq set at DONE when final count != 0, cleared by irq_clr=1; set wins on same cycle; reset clears.
REQ-028 Without SEQ_MATCH_IRQ_EN SHALL omit irq and irq_clr ports and logic; all other behaviour identical.

Verification
REQ-029 req0 sends 8'b0011_0011 -> ser_bit 0,0,1,1,0,0,1,1; det_z high on bit 4 and bit 8; done 9 cycles after handshake, match_cnt=2, done_id=0.
REQ-030 req1 sends 8'b0000_0011 -> match_cnt=1, done_id=1; 8'b1111_1111 -> match_cnt=0.
REQ-031 After reset both valid held high -> grants req0, req1, req0 in order; exactly one ready high per IDLE cycle.
REQ-032 Reset asserted at 4th SHIFT cycle -> no done, outputs at reset values next cycle, next transaction counts from 0.
REQ-033 SEQ_MATCH_IRQ_EN build: word 8'b0000_0011 -> irq rises with done; irq_clr pulse -> irq 0; irq_clr coincident with a new match DONE -> irq stays 1.
